sdram_rr_scheduler: RTL and testbench
=====================================

# sdram_rr_scheduler

Shares the single 128-bit SDRAM master port (ar_* bus into the SDRAM controller) among N_REQ requesters: line buffer, background, sprite/score writer and I2S fetcher. Arbitration is round-robin, with a scanline-deadline override that gives requester 0 (line buffer) absolute priority near the end of each line. The block sits between the requester FSMs and the SDRAM controller. It replaces fixed frame-phase sequencing with per-transaction grants.

## Interface
Parameters:
- N_REQ, 4: number of requesters; index 0 is the deadline-critical line buffer.
- ADDR_W, 22: SDRAM word address width.
- DATA_W, 128: data width.
- BE_W, 16: byte-enable width (DATA_W/8).
- URG_X, 770: DrawX value at or above which requester 0 is urgent.
- TIMEOUT, 1023: GRANT cycles without ar_ac before the timeout flag sets.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- DrawX  in  10  current pixel column (0..799).
- req_rd  in  N_REQ  per-requester read request. Level; held until its ac.
- req_wr  in  N_REQ  per-requester write request. Level; held until its ac.
- req_addr  in  N_REQ*ADDR_W  packed addresses; slice i = [i*ADDR_W +: ADDR_W].
- req_wrdata  in  N_REQ*DATA_W  packed write data.
- req_be  in  N_REQ*BE_W  packed byte enables (writes only).
- req_ac  out  N_REQ  one-hot acknowledge pulse.
- req_wait  out  N_REQ  1 = not granted; 0 = port owned by this requester.
- rd_data  out  DATA_W  broadcast of ar_rddata. Valid for requester i only when req_ac[i]=1 on a read.
- ar_addr  out  ADDR_W  SDRAM address.
- ar_be  out  BE_W  SDRAM byte enables.
- ar_read  out  1  SDRAM read strobe.
- ar_write  out  1  SDRAM write strobe.
- ar_wrdata  out  DATA_W  SDRAM write data.
- ar_rddata  in  DATA_W  SDRAM read data.
- ar_ac  in  1  SDRAM acknowledge; completes the current transaction.
- busy  out  1  1 while in GRANT.
- err_timeout  out  1  sticky: a grant exceeded TIMEOUT cycles.
- err_proto  out  1  sticky: a requester asserted rd and wr together.

## Operation
- States: IDLE, GRANT. Registers: gnt_idx, is_write, rr_ptr, to_cnt.
- Requester i is active when req_rd[i] or req_wr[i] is set.
- urgent = (DrawX >= URG_X) && (DrawX <= 799).
- IDLE, winner selection:
  - If urgent and requester 0 is active, requester 0 wins.
  - Otherwise, search indices rr_ptr+1, rr_ptr+2, … mod N_REQ and take the first active one.
- IDLE, on a winner:
  - Register gnt_idx and is_write (= req_wr of the winner); go to GRANT.
  - Set rr_ptr to the winner only if the win was not an urgent override. An override does not advance the pointer.
- GRANT, driven outputs:
  - ar_addr, ar_be and ar_wrdata come from slice gnt_idx.
  - ar_write = is_write; ar_read = ~is_write.
  - req_wait[gnt_idx] = 0.
  - req_ac[gnt_idx] = ar_ac, combinational pass-through.
- GRANT, on ar_ac: return to IDLE. IDLE always drives ar_read = ar_write = 0, so there is a mandatory one-cycle bubble that lets the requester drop or update its request.
- rd and wr asserted together by the winner: treated as a write; err_proto sets.
- Outside GRANT: ar_be = all ones, ar_addr = 0, ar_wrdata = 0.
- A request deasserted while granted is a protocol violation. The block keeps driving the latched type from the live slice until ar_ac.

## Timing
- Reset values:
  - State = IDLE.
  - rr_ptr = N_REQ-1, so requester 0 is searched first.
  - to_cnt = 0.
  - All req_ac = 0; all req_wait = 1.
  - ar_read = ar_write = 0; ar_addr = 0; ar_be = all ones; ar_wrdata = 0.
  - busy = 0; err_timeout = 0; err_proto = 0.
- Request latency: request seen in IDLE at edge t → ar_* driven from cycle t+1.
- Minimum spacing is 2 cycles per transaction when ar_ac returns on the first GRANT cycle.
- to_cnt:
  - Increments in each GRANT cycle without ar_ac; clears on ar_ac and in IDLE.
  - At to_cnt == TIMEOUT, err_timeout sets. The grant is held; no transaction is dropped.
- urgent is evaluated only in IDLE. A grant in progress is never preempted.
- Wrap-around: rr_ptr = N_REQ-1 → search starts at 0.
- Reset mid-GRANT: the next edge returns to IDLE with all strobes low. An in-flight ar_ac on that edge is ignored.
- Error flags clear only on reset.

## Test plan
- Single read: req_rd[2]=1, addr 0x00123. Expect ar_read=1 and ar_addr=0x00123 one cycle later. Reply ar_ac with ar_rddata=0xA5…A5. Expect req_ac[2]=1 and rd_data=0xA5…A5 in that cycle, then ar_read=0 on the next cycle.
- Round-robin fairness: requesters 1, 2, 3 hold requests continuously; ar_ac returns after 1 cycle. Expect grant order 1, 2, 3, 1, 2, 3 with a bubble between each.
- Urgent override: rr_ptr=0, requesters 0 and 1 active, DrawX=770. Expect requester 0 granted and rr_ptr unchanged. With DrawX=500 under the same stimulus, expect requester 1 granted.
- Masked write: req_wr[3]=1, be=16'h00F0. Expect ar_write=1 and ar_be=16'h00F0; after ar_ac, ar_be returns to 16'hFFFF.
- Timeout: with TIMEOUT=7, grant requester 1 and hold ar_ac=0. Expect err_timeout=1 after 7 GRANT cycles and busy still 1. A later ar_ac completes normally.
- Reset mid-GRANT: assert reset during a write. Expect ar_write=0, all req_wait=1 and busy=0 after the edge. err_proto is asserted by a rd+wr test beforehand and is cleared by this reset.

Source files
------------

// File: rtl/sdram_rr_scheduler.sv
// Round-robin arbiter sharing one SDRAM master port among N_REQ requesters.
// Requester 0 (line buffer) can override the rotation near the end of each scanline.
module sdram_rr_scheduler #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 22,
    parameter int DATA_W  = 128,
    parameter int BE_W    = 16,
    parameter int URG_X   = 770,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [9:0]              DrawX,
    input  logic [N_REQ-1:0]        req_rd,
    input  logic [N_REQ-1:0]        req_wr,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wrdata,
    input  logic [N_REQ*BE_W-1:0]   req_be,
    output logic [N_REQ-1:0]        req_ac,
    output logic [N_REQ-1:0]        req_wait,
    output logic [DATA_W-1:0]       rd_data,
    output logic [ADDR_W-1:0]       ar_addr,
    output logic [BE_W-1:0]         ar_be,
    output logic                    ar_read,
    output logic                    ar_write,
    output logic [DATA_W-1:0]       ar_wrdata,
    input  logic [DATA_W-1:0]       ar_rddata,
    input  logic                    ar_ac,
    output logic                    busy,
    output logic                    err_timeout,
    output logic                    err_proto
);

    // Handshake: a requester holds req_rd/req_wr until the cycle its req_ac pulses;
    // the transaction completes on the cycle ar_ac is high while in GRANT.

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_PRE = TO_W'(TIMEOUT - 1);
    localparam logic [9:0] URG_LO = 10'(URG_X);
    localparam logic [9:0] X_LAST = 10'd799;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] rr_ptr;
    logic             is_write;
    logic [TO_W-1:0]  to_cnt;

    logic [N_REQ-1:0] active;
    logic             urgent;
    logic             win_found;
    logic             win_urgent;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] cand;

    assign active  = req_rd | req_wr;
    assign urgent  = (DrawX >= URG_LO) && (DrawX <= X_LAST);
    assign busy    = (state == GRANT);
    assign rd_data = ar_rddata;

    always_comb begin
        win_found  = 1'b0;
        win_urgent = 1'b0;
        win_idx    = '0;
        cand       = '0;
        if (urgent && active[0]) begin
            win_found  = 1'b1;
            win_urgent = 1'b1;
        end else begin
            for (int k = 1; k <= N_REQ; k++) begin
                cand = PTR_W'((int'(rr_ptr) + k) % N_REQ);
                if (!win_found && active[cand]) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                end
            end
        end
    end

    // Port outputs follow the live slice of the granted requester.
    always_comb begin
        req_ac    = '0;
        req_wait  = '1;
        ar_addr   = '0;
        ar_be     = '1;
        ar_wrdata = '0;
        ar_read   = 1'b0;
        ar_write  = 1'b0;
        if (state == GRANT) begin
            req_ac[gnt_idx]   = ar_ac;
            req_wait[gnt_idx] = 1'b0;
            ar_addr   = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
            ar_be     = req_be[int'(gnt_idx)*BE_W +: BE_W];
            ar_wrdata = req_wrdata[int'(gnt_idx)*DATA_W +: DATA_W];
            ar_write  = is_write;
            ar_read   = ~is_write;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            gnt_idx     <= '0;
            rr_ptr      <= PTR_W'(N_REQ - 1);
            is_write    <= 1'b0;
            to_cnt      <= '0;
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (win_found) begin
                        state    <= GRANT;
                        gnt_idx  <= win_idx;
                        is_write <= req_wr[win_idx];
                        // An urgent override leaves the rotation where it was.
                        if (!win_urgent)
                            rr_ptr <= win_idx;
                        if (req_rd[win_idx] && req_wr[win_idx])
                            err_proto <= 1'b1;
                    end
                end
                GRANT: begin
                    if (ar_ac) begin
                        state  <= IDLE;
                        to_cnt <= '0;
                    end else begin
                        if (to_cnt != TO_MAX)
                            to_cnt <= to_cnt + 1'b1;
                        if (to_cnt >= TO_PRE)
                            err_timeout <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_rr_scheduler.sv
// Directed plus randomized bench for sdram_rr_scheduler, checked against an
// arbitration model built from the grant rules (urgent override, rotating search).
module tb_sdram_rr_scheduler;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [9:0]     DrawX;
    logic [N-1:0]   req_rd;
    logic [N-1:0]   req_wr;
    logic [N*22-1:0]  req_addr;
    logic [N*128-1:0] req_wrdata;
    logic [N*16-1:0]  req_be;
    logic [N-1:0]   req_ac;
    logic [N-1:0]   req_wait;
    logic [127:0]   rd_data;
    logic [21:0]    ar_addr;
    logic [15:0]    ar_be;
    logic           ar_read;
    logic           ar_write;
    logic [127:0]   ar_wrdata;
    logic [127:0]   ar_rddata;
    logic           ar_ac;
    logic           busy;
    logic           err_timeout;
    logic           err_proto;

    sdram_rr_scheduler #(.N_REQ(N), .TIMEOUT(7)) dut (
        .clk(clk), .reset(reset), .DrawX(DrawX),
        .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
        .req_wrdata(req_wrdata), .req_be(req_be),
        .req_ac(req_ac), .req_wait(req_wait), .rd_data(rd_data),
        .ar_addr(ar_addr), .ar_be(ar_be), .ar_read(ar_read), .ar_write(ar_write),
        .ar_wrdata(ar_wrdata), .ar_rddata(ar_rddata), .ar_ac(ar_ac),
        .busy(busy), .err_timeout(err_timeout), .err_proto(err_proto)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;
    int model_last;
    logic [21:0]  a_addr[N];
    logic [127:0] a_data[N];
    logic [15:0]  a_be[N];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_slices();
        for (int i = 0; i < N; i++) begin
            req_addr[i*22 +: 22]    = a_addr[i];
            req_wrdata[i*128 +: 128] = a_data[i];
            req_be[i*16 +: 16]      = a_be[i];
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit is_urgent(input logic [9:0] dx);
        return (dx >= 10'd770) && (dx <= 10'd799);
    endfunction

    // Reference: urgent line buffer first, else next active after the last rotating winner.
    function automatic int model_pick(input logic [N-1:0] act, input logic [9:0] dx);
        if (is_urgent(dx) && act[0]) return 0;
        for (int k = 1; k <= N; k++) begin
            if (act[(model_last + k) % N]) return (model_last + k) % N;
        end
        return -1;
    endfunction

    task automatic run_txn(input logic [N-1:0] rd, input logic [N-1:0] wr,
                           input logic [9:0] dx, input int exp, input int lat,
                           input logic [127:0] rdd);
        logic [N-1:0] one_hot;
        logic [N-1:0] wait_exp;
        one_hot  = '0;
        one_hot[exp] = 1'b1;
        wait_exp = ~one_hot;
        req_rd = rd;
        req_wr = wr;
        DrawX  = dx;
        apply_slices();
        tick();
        chk("grant_busy", busy, 1);
        chk("grant_wait", wait_exp, req_wait == wait_exp ? wait_exp : req_wait);
        chk("grant_wait_vec", req_wait, wait_exp);
        chk("grant_read", ar_read, !wr[exp]);
        chk("grant_write", ar_write, wr[exp]);
        chk("grant_addr", ar_addr, a_addr[exp]);
        chk("grant_be", ar_be, a_be[exp]);
        chk("grant_wdata", ar_wrdata, a_data[exp]);
        chk("grant_no_ac", req_ac, 0);
        repeat (lat) begin
            tick();
            chk("hold_busy", busy, 1);
            chk("hold_no_ac", req_ac, 0);
        end
        ar_ac     = 1'b1;
        ar_rddata = rdd;
        #1;
        chk("ack_onehot", req_ac, one_hot);
        chk("ack_rddata", rd_data, rdd);
        tick();
        ar_ac  = 1'b0;
        req_rd = '0;
        req_wr = '0;
        #1;
        chk("bubble_busy", busy, 0);
        chk("bubble_read", ar_read, 0);
        chk("bubble_write", ar_write, 0);
        chk("bubble_be", ar_be, 16'hFFFF);
        chk("bubble_addr", ar_addr, 0);
        chk("bubble_wait", req_wait, 4'hF);
        if (!(is_urgent(dx) && (rd[0] || wr[0])))
            model_last = exp;
    endtask

    initial begin
        logic [N-1:0] rd;
        logic [N-1:0] wr;
        logic [9:0]   dx;
        int           w;
        reset = 1'b1;
        DrawX = '0;
        req_rd = '0;
        req_wr = '0;
        ar_ac = 1'b0;
        ar_rddata = '0;
        for (int i = 0; i < N; i++) begin
            a_addr[i] = 22'($urandom);
            a_data[i] = rnd128();
            a_be[i]   = 16'($urandom);
        end
        apply_slices();
        repeat (3) tick();
        reset = 1'b0;
        model_last = N - 1;
        #1;
        chk("rst_ac", req_ac, 0);
        chk("rst_wait", req_wait, 4'hF);
        chk("rst_read", ar_read, 0);
        chk("rst_write", ar_write, 0);
        chk("rst_addr", ar_addr, 0);
        chk("rst_be", ar_be, 16'hFFFF);
        chk("rst_wdata", ar_wrdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_to", err_timeout, 0);
        chk("rst_err_proto", err_proto, 0);

        // Round-robin among 1,2,3 starting from the reset pointer.
        for (int j = 0; j < 6; j++)
            run_txn(4'b1110, 4'b0000, 10'd0, (j % 3) + 1, 0, rnd128());

        a_addr[2] = 22'h00123;
        run_txn(4'b0100, 4'b0000, 10'd0, 2, 0, {16{8'hA5}});

        // Urgency window and pointer behaviour around the override.
        run_txn(4'b0001, 4'b0000, 10'd0,   0, 1, rnd128());
        run_txn(4'b0011, 4'b0000, 10'd770, 0, 0, rnd128());
        run_txn(4'b0011, 4'b0000, 10'd500, 1, 0, rnd128());
        run_txn(4'b0101, 4'b0000, 10'd769, 2, 2, rnd128());
        run_txn(4'b1001, 4'b0000, 10'd799, 0, 0, rnd128());
        run_txn(4'b1001, 4'b0000, 10'd800, 3, 0, rnd128());

        a_be[3] = 16'h00F0;
        run_txn(4'b0000, 4'b1000, 10'd0, 3, 0, rnd128());

        run_txn(4'b0100, 4'b0100, 10'd0, 2, 0, rnd128());
        chk("proto_set", err_proto, 1);
        chk("proto_no_to", err_timeout, 0);

        // Timeout: seven GRANT cycles without ar_ac.
        req_rd = 4'b0010;
        tick();
        chk("to_busy", busy, 1);
        repeat (6) begin
            tick();
            chk("to_not_yet", err_timeout, 0);
        end
        tick();
        chk("to_set", err_timeout, 1);
        chk("to_still_busy", busy, 1);
        chk("to_wait", req_wait, 4'b1101);
        ar_ac = 1'b1;
        #1;
        chk("to_ack", req_ac, 4'b0010);
        tick();
        ar_ac  = 1'b0;
        req_rd = '0;
        #1;
        chk("to_done_busy", busy, 0);
        chk("to_sticky", err_timeout, 1);
        model_last = 1;

        // Reset during a write grant, with an ar_ac on the same edge.
        req_wr = 4'b1000;
        tick();
        chk("rstg_write", ar_write, 1);
        reset = 1'b1;
        ar_ac = 1'b1;
        tick();
        chk("rstg_write_low", ar_write, 0);
        chk("rstg_wait", req_wait, 4'hF);
        chk("rstg_busy", busy, 0);
        chk("rstg_ac", req_ac, 0);
        chk("rstg_proto_clr", err_proto, 0);
        chk("rstg_to_clr", err_timeout, 0);
        reset  = 1'b0;
        ar_ac  = 1'b0;
        req_wr = '0;
        model_last = N - 1;
        tick();
        chk("rstg_idle", busy, 0);

        // Randomized traffic against the arbitration model.
        for (int it = 0; it < 150; it++) begin
            rd = '0;
            wr = '0;
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    1, 3: rd[i] = 1'b1;
                    2: wr[i] = 1'b1;
                    default: ;
                endcase
                a_addr[i] = 22'($urandom);
                a_data[i] = rnd128();
                a_be[i]   = 16'($urandom);
            end
            dx = $urandom_range(0, 1) ? 10'($urandom_range(760, 805)) : 10'($urandom_range(0, 1023));
            if ((rd | wr) == '0) begin
                DrawX = dx;
                req_rd = '0;
                req_wr = '0;
                tick();
                chk("rand_idle_busy", busy, 0);
                chk("rand_idle_wait", req_wait, 4'hF);
            end else begin
                w = model_pick(rd | wr, dx);
                run_txn(rd, wr, dx, w, $urandom_range(0, 3), rnd128());
            end
        end
        chk("rand_no_timeout", err_timeout, 0);
        chk("rand_no_proto", err_proto, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
